// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command scheduler slice:
//   - ASCII constants for the recognised command letters and status replies
//   - cmd_class_t   : decoded class of a received command byte
//   - sched_state_t : scheduler FSM states
// Optional build macro: CMD_STATUS_EN adds the two status-report states.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam logic [7:0] CH_R_UP = 8'h52;  // 'R'
  localparam logic [7:0] CH_R_LO = 8'h72;  // 'r'
  localparam logic [7:0] CH_C_UP = 8'h43;  // 'C'
  localparam logic [7:0] CH_C_LO = 8'h63;  // 'c'
  localparam logic [7:0] CH_M_UP = 8'h4D;  // 'M'
  localparam logic [7:0] CH_M_LO = 8'h6D;  // 'm'
  localparam logic [7:0] CH_S_UP = 8'h53;  // 'S'
  localparam logic [7:0] CH_S_LO = 8'h73;  // 's'
  localparam logic [7:0] CH_U    = 8'h55;  // 'U'
  localparam logic [7:0] CH_D    = 8'h44;  // 'D'

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RUN,
    CMD_CLR,
    CMD_MODE,
    CMD_STAT,
    CMD_INV
  } cmd_class_t;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    ACK
`ifdef CMD_STATUS_EN
    ,
    STAT_RUN,
    STAT_MODE
`endif
  } sched_state_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// ---------------------------------------------------------------------------
// uart_cmd_decode
// Purely combinational classifier: one command byte -> cmd_class_t.
// Letters are accepted in either case. Kept separate so later command
// extensions only touch this file.
// Ports:
//   cmd_byte  in  DATA_W  byte to classify
//   cmd_class out cmd_class_t  decoded class (CMD_INV for anything unknown)
// Optional build macro: CMD_STATUS_EN makes 'S'/'s' decode as CMD_STAT;
// without it those letters are treated as unrecognised.
// ---------------------------------------------------------------------------
module uart_cmd_decode
  import uart_cmd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] cmd_byte,
  output cmd_class_t        cmd_class
);

  always_comb begin
    cmd_class = CMD_INV;
    if (cmd_byte == DATA_W'(CH_R_UP) || cmd_byte == DATA_W'(CH_R_LO)) begin
      cmd_class = CMD_RUN;
    end else if (cmd_byte == DATA_W'(CH_C_UP) || cmd_byte == DATA_W'(CH_C_LO)) begin
      cmd_class = CMD_CLR;
    end else if (cmd_byte == DATA_W'(CH_M_UP) || cmd_byte == DATA_W'(CH_M_LO)) begin
      cmd_class = CMD_MODE;
`ifdef CMD_STATUS_EN
    end else if (cmd_byte == DATA_W'(CH_S_UP) || cmd_byte == DATA_W'(CH_S_LO)) begin
      cmd_class = CMD_STAT;
`endif
    end
  end

endmodule

// File: rtl/uart_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// uart_cmd_scheduler
// Merges UART commands (from the RX FIFO) and debounced button pulses onto
// single-cycle run/clear/mode strobes for the counter controller, mirrors the
// resulting run and mode state, and answers every UART command through the
// TX FIFO with an echo (or ERR_CHAR for unknown bytes).
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   rx_empty, rx_rdata       RX FIFO status / head byte (first-word-fall-through)
//   rx_pop                   RX FIFO pop strobe
//   tx_full                  TX FIFO full
//   tx_wdata, tx_push        TX FIFO write data / push strobe
//   btn_run/clear/mode       debounced single-cycle button pulses
//   run_tgl, clr_p, mode_tgl one-cycle strobes to the counter controller
//   run_st, mode_st          mirrored run and mode state
//   busy                     high whenever the FSM is outside IDLE
// Optional build macro: CMD_STATUS_EN enables the 'S' command, which follows
// its echo with a run character ('R'/'S') and a mode character ('D'/'U').
// ---------------------------------------------------------------------------
module uart_cmd_scheduler
  import uart_cmd_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] ERR_CHAR = DATA_W'(8'h3F),
  parameter logic              MODE_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_rdata,
  output logic              rx_pop,
  input  logic              tx_full,
  output logic [DATA_W-1:0] tx_wdata,
  output logic              tx_push,
  input  logic              btn_run,
  input  logic              btn_clear,
  input  logic              btn_mode,
  output logic              run_tgl,
  output logic              clr_p,
  output logic              mode_tgl,
  output logic              run_st,
  output logic              mode_st,
  output logic              busy
);

  sched_state_t      state_q, state_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  cmd_class_t        cls_q, cls_d;
  cmd_class_t        dec_class;
  logic              run_st_q, run_st_d;
  logic              mode_st_q, mode_st_d;
  logic              any_btn;
  logic              uart_run, uart_clr, uart_mode;

  uart_cmd_decode #(
    .DATA_W(DATA_W)
  ) u_decode (
    .cmd_byte (cmd_q),
    .cmd_class(dec_class)
  );

  assign any_btn = btn_run | btn_clear | btn_mode;

  // A UART strobe is only issued in a cycle with no button pulse at all, so
  // the two sources never land on the same strobe cycle and no toggle is lost.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cls_d     = cls_q;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    tx_wdata  = '0;
    uart_run  = 1'b0;
    uart_clr  = 1'b0;
    uart_mode = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          rx_pop  = 1'b1;
          cmd_d   = rx_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        cls_d   = dec_class;
        state_d = EXEC;
      end
      EXEC: begin
        if (cls_q == CMD_RUN || cls_q == CMD_CLR || cls_q == CMD_MODE) begin
          if (!any_btn) begin
            uart_run  = (cls_q == CMD_RUN);
            uart_clr  = (cls_q == CMD_CLR);
            uart_mode = (cls_q == CMD_MODE);
            state_d   = ACK;
          end
        end else begin
          state_d = ACK;
        end
      end
      ACK: begin
        tx_wdata = (cls_q == CMD_INV) ? ERR_CHAR : cmd_q;
        if (!tx_full) begin
          tx_push = 1'b1;
`ifdef CMD_STATUS_EN
          state_d = (cls_q == CMD_STAT) ? STAT_RUN : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef CMD_STATUS_EN
      // Status characters read the mirror at their own push cycle, so any
      // button activity while waiting on tx_full is reflected.
      STAT_RUN: begin
        tx_wdata = run_st_q ? DATA_W'(CH_R_UP) : DATA_W'(CH_S_UP);
        if (!tx_full) begin
          tx_push = 1'b1;
          state_d = STAT_MODE;
        end
      end
      STAT_MODE: begin
        tx_wdata = mode_st_q ? DATA_W'(CH_D) : DATA_W'(CH_U);
        if (!tx_full) begin
          tx_push = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buttons reach the strobes combinationally in their own cycle.
  always_comb begin
    run_tgl   = btn_run | uart_run;
    clr_p     = btn_clear | uart_clr;
    mode_tgl  = btn_mode | uart_mode;
    run_st_d  = run_st_q ^ run_tgl;
    mode_st_d = mode_st_q ^ mode_tgl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cls_q     <= CMD_NONE;
      run_st_q  <= 1'b0;
      mode_st_q <= MODE_RST;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cls_q     <= cls_d;
      run_st_q  <= run_st_d;
      mode_st_q <= mode_st_d;
    end
  end

  assign run_st  = run_st_q;
  assign mode_st = mode_st_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_scheduler
// Self-checking bench for uart_cmd_scheduler: directed vector table with
// cycle-offset strobe masks, a reset-mid-command sequence, then a randomized
// run against a transaction-level model of the command/response stream.
// Honours CMD_STATUS_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_scheduler;

  localparam logic MODE_RST = 1'b0;

`ifdef CMD_STATUS_EN
  localparam logic [7:0] S_ECHO = 8'h73;
`else
  localparam logic [7:0] S_ECHO = 8'h3F;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_rdata = 8'h00;
  logic       tx_full = 1'b0;
  logic       btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
  logic       rx_pop, tx_push, run_tgl, clr_p, mode_tgl, run_st, mode_st, busy;
  logic [7:0] tx_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_scheduler #(
    .DATA_W  (8),
    .ERR_CHAR(8'h3F),
    .MODE_RST(MODE_RST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .rx_rdata (rx_rdata),
    .rx_pop   (rx_pop),
    .tx_full  (tx_full),
    .tx_wdata (tx_wdata),
    .tx_push  (tx_push),
    .btn_run  (btn_run),
    .btn_clear(btn_clear),
    .btn_mode (btn_mode),
    .run_tgl  (run_tgl),
    .clr_p    (clr_p),
    .mode_tgl (mode_tgl),
    .run_st   (run_st),
    .mode_st  (mode_st),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Generic comparison used by every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Monitor: append-only event logs plus the random-phase stream model.
  // ------------------------------------------------------------------
  int         pop_ev[$];
  int         run_ev[$], clr_ev[$], mode_ev[$];
  logic [7:0] tx_log[$];
  int         viol = 0;
  bit         rand_mode = 1'b0;
  int         exp_q[$];   // >=0 literal byte, -1 run char, -2 mode char
  int         btn_run_cnt, btn_clr_cnt, btn_mode_cnt;
  int         uart_run_cnt, uart_clr_cnt, uart_mode_cnt;
  int         act_run_cnt, act_clr_cnt, act_mode_cnt;

  task automatic modelCmd(input logic [7:0] b);
    case (b)
      8'h52, 8'h72: begin uart_run_cnt++;  exp_q.push_back(int'(b)); end
      8'h43, 8'h63: begin uart_clr_cnt++;  exp_q.push_back(int'(b)); end
      8'h4D, 8'h6D: begin uart_mode_cnt++; exp_q.push_back(int'(b)); end
`ifdef CMD_STATUS_EN
      8'h53, 8'h73: begin exp_q.push_back(int'(b)); exp_q.push_back(-1); exp_q.push_back(-2); end
`endif
      default: exp_q.push_back(32'h3F);
    endcase
  endtask

  always @(negedge clk) begin
    int         e;
    logic [7:0] eb;
    if (!rst) begin
      btn_run_cnt = 0; btn_clr_cnt = 0; btn_mode_cnt = 0;
      uart_run_cnt = 0; uart_clr_cnt = 0; uart_mode_cnt = 0;
      act_run_cnt = 0; act_clr_cnt = 0; act_mode_cnt = 0;
      exp_q.delete();
    end
    if (rx_pop) begin
      if (rx_empty) viol++;
      else begin
        pop_ev.push_back(cyc);
        if (rand_mode) modelCmd(rx_rdata);
      end
    end
    if (run_tgl)  run_ev.push_back(cyc);
    if (clr_p)    clr_ev.push_back(cyc);
    if (mode_tgl) mode_ev.push_back(cyc);
    if (tx_push) begin
      if (tx_full) viol++;
      else begin
        tx_log.push_back(tx_wdata);
        if (rand_mode) begin
          if (exp_q.size() == 0) begin
            checkOutput("rand_tx_unexpected", {24'h0, tx_wdata}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            // Status chars reflect every toggle seen before this cycle.
            if (e >= 0) eb = e[7:0];
            else if (e == -1) eb = ((btn_run_cnt + uart_run_cnt) % 2 == 1) ? 8'h52 : 8'h53;
            else eb = ((MODE_RST ^ ((btn_mode_cnt + uart_mode_cnt) % 2 == 1)) == 1'b1) ? 8'h44 : 8'h55;
            checkOutput("rand_tx_byte", {24'h0, tx_wdata}, {24'h0, eb});
          end
        end
      end
    end
    act_run_cnt  += int'(run_tgl);
    act_clr_cnt  += int'(clr_p);
    act_mode_cnt += int'(mode_tgl);
    btn_run_cnt  += int'(btn_run);
    btn_clr_cnt  += int'(btn_clear);
    btn_mode_cnt += int'(btn_mode);
  end

  function automatic logic [15:0] maskOf(input int q[$], input int base);
    logic [15:0] m = '0;
    foreach (q[k]) begin
      if (q[k] >= base && q[k] - base < 16) m[q[k] - base] = 1'b1;
    end
    return m;
  endfunction

  // ------------------------------------------------------------------
  // Directed vectors: strobe masks are bit offsets from the pop cycle.
  // ------------------------------------------------------------------
  typedef struct {
    logic [7:0]  cmd;
    int          btn;        // 0 none, 1 run, 2 clear, 3 mode (driven in EXEC)
    bit          hold_full;
    logic [7:0]  echo;
    logic [15:0] run_m;
    logic [15:0] clr_m;
    logic [15:0] mode_m;
    bit          stat;
  } vec_t;

  vec_t vecs[10];
  logic exp_run, exp_mode;

  task automatic applyStimulus(input vec_t v);
    int guard;
    @(posedge clk); #1;
    rx_rdata = v.cmd; rx_empty = 1'b0; tx_full = v.hold_full;
    @(posedge clk); #1;
    rx_empty = 1'b1; rx_rdata = 8'h00;
    @(posedge clk); #1;
    btn_run = (v.btn == 1); btn_clear = (v.btn == 2); btn_mode = (v.btn == 3);
    @(posedge clk); #1;
    btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
    if (v.hold_full) begin
      repeat (4) begin
        @(negedge clk);
        checkOutput("hold_no_push", {31'h0, tx_push}, 32'h0);
        checkOutput("hold_busy", {31'h0, busy}, 32'h1);
      end
      @(posedge clk); #1;
      tx_full = 1'b0;
    end
    guard = 0;
    while (busy && guard < 30) begin @(posedge clk); #1; guard++; end
    checkOutput("return_to_idle", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [7:0] picks[10];
  logic [7:0] rx_q[$];

  initial begin
    int         n_pop0, tx0, base, popped, guard;
    logic [7:0] exp_tx[$];

    vecs[0] = '{8'h52, 0, 1'b0, 8'h52,   16'h0004, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{8'h63, 1, 1'b0, 8'h63,   16'h0004, 16'h0008, 16'h0000, 1'b0};
    vecs[2] = '{8'h78, 0, 1'b0, 8'h3F,   16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{8'h4D, 0, 1'b1, 8'h4D,   16'h0000, 16'h0000, 16'h0004, 1'b0};
    vecs[4] = '{8'h73, 0, 1'b0, S_ECHO,  16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{8'h6D, 3, 1'b0, 8'h6D,   16'h0000, 16'h0000, 16'h000C, 1'b0};
    vecs[6] = '{8'h43, 0, 1'b0, 8'h43,   16'h0000, 16'h0004, 16'h0000, 1'b0};
    vecs[7] = '{8'h72, 3, 1'b0, 8'h72,   16'h0008, 16'h0000, 16'h0004, 1'b0};
    vecs[8] = '{8'h52, 2, 1'b0, 8'h52,   16'h0008, 16'h0004, 16'h0000, 1'b0};
    vecs[9] = '{8'h51, 1, 1'b0, 8'h3F,   16'h0004, 16'h0000, 16'h0000, 1'b0};
    picks = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D, 8'h53, 8'h73, 8'h78, 8'h00};

    // Reset state, observed while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rx_pop",   {31'h0, rx_pop},   32'h0);
    checkOutput("rst_tx_push",  {31'h0, tx_push},  32'h0);
    checkOutput("rst_tx_wdata", {24'h0, tx_wdata}, 32'h0);
    checkOutput("rst_strobes",  {29'h0, run_tgl, clr_p, mode_tgl}, 32'h0);
    checkOutput("rst_run_st",   {31'h0, run_st},   32'h0);
    checkOutput("rst_mode_st",  {31'h0, mode_st},  {31'h0, MODE_RST});
    checkOutput("rst_busy",     {31'h0, busy},     32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_run = 1'b0; exp_mode = MODE_RST;

    for (int i = 0; i < 10; i++) begin
      n_pop0 = pop_ev.size();
      tx0    = tx_log.size();
      applyStimulus(vecs[i]);
      exp_run  = exp_run  ^ (^vecs[i].run_m);
      exp_mode = exp_mode ^ (^vecs[i].mode_m);
      exp_tx.delete();
      exp_tx.push_back(vecs[i].echo);
`ifdef CMD_STATUS_EN
      if (vecs[i].stat) begin
        exp_tx.push_back(exp_run ? 8'h52 : 8'h53);
        exp_tx.push_back(exp_mode ? 8'h44 : 8'h55);
      end
`endif
      checkOutput($sformatf("v%0d_pop_count", i), pop_ev.size() - n_pop0, 1);
      base = (pop_ev.size() > n_pop0) ? pop_ev[n_pop0] : -1000;
      checkOutput($sformatf("v%0d_run_mask", i),  {16'h0, maskOf(run_ev, base)},  {16'h0, vecs[i].run_m});
      checkOutput($sformatf("v%0d_clr_mask", i),  {16'h0, maskOf(clr_ev, base)},  {16'h0, vecs[i].clr_m});
      checkOutput($sformatf("v%0d_mode_mask", i), {16'h0, maskOf(mode_ev, base)}, {16'h0, vecs[i].mode_m});
      checkOutput($sformatf("v%0d_tx_count", i), tx_log.size() - tx0, exp_tx.size());
      for (int k = 0; k < exp_tx.size() && tx0 + k < tx_log.size(); k++)
        checkOutput($sformatf("v%0d_tx_byte%0d", i, k), {24'h0, tx_log[tx0 + k]}, {24'h0, exp_tx[k]});
      checkOutput($sformatf("v%0d_run_st", i),  {31'h0, run_st},  {31'h0, exp_run});
      checkOutput($sformatf("v%0d_mode_st", i), {31'h0, mode_st}, {31'h0, exp_mode});
    end

    // Reset while the command sits in DECODE: nothing of it may survive.
    tx0 = tx_log.size();
    base = cyc;
    @(posedge clk); #1;
    rx_rdata = 8'h52; rx_empty = 1'b0;
    @(posedge clk); #1;
    rx_empty = 1'b1; rx_rdata = 8'h00;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_run_strobes", {16'h0, maskOf(run_ev, base)}, 32'h0);
    checkOutput("midrst_tx_count", tx_log.size() - tx0, 0);
    checkOutput("midrst_run_st", {31'h0, run_st}, 32'h0);
    checkOutput("midrst_mode_st", {31'h0, mode_st}, {31'h0, MODE_RST});
    checkOutput("midrst_busy_after", {31'h0, busy}, 32'h0);

    // Randomized phase against the stream model.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rx_q.delete();
    popped = pop_ev.size();
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      while (popped < pop_ev.size()) begin void'(rx_q.pop_front()); popped++; end
      if (rx_q.size() < 4 && $urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 9) == 9) rx_q.push_back(8'($urandom_range(0, 255)));
        else rx_q.push_back(picks[$urandom_range(0, 8)]);
      end
      btn_run   = ($urandom_range(0, 15) == 0);
      btn_clear = ($urandom_range(0, 15) == 0);
      btn_mode  = ($urandom_range(0, 15) == 0);
      tx_full   = ($urandom_range(0, 3) == 0);
      rx_empty  = (rx_q.size() == 0);
      rx_rdata  = rx_empty ? 8'h00 : rx_q[0];
    end
    btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0; tx_full = 1'b0;
    guard = 0;
    while ((rx_q.size() != 0 || busy) && guard < 500) begin
      @(posedge clk); #1;
      while (popped < pop_ev.size()) begin void'(rx_q.pop_front()); popped++; end
      rx_empty = (rx_q.size() == 0);
      rx_rdata = rx_empty ? 8'h00 : rx_q[0];
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rand_drained", {31'h0, busy}, 32'h0);
    checkOutput("rand_tx_missing", exp_q.size(), 0);
    checkOutput("rand_run_count",  act_run_cnt,  btn_run_cnt + uart_run_cnt);
    checkOutput("rand_clr_count",  act_clr_cnt,  btn_clr_cnt + uart_clr_cnt);
    checkOutput("rand_mode_count", act_mode_cnt, btn_mode_cnt + uart_mode_cnt);
    checkOutput("rand_run_st",  {31'h0, run_st},  (btn_run_cnt + uart_run_cnt) % 2);
    checkOutput("rand_mode_st", {31'h0, mode_st}, {31'h0, MODE_RST ^ ((btn_mode_cnt + uart_mode_cnt) % 2 == 1)});
    checkOutput("fifo_protocol_violations", viol, 0);
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
